// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bundle for the pipelined ALU.
package alu_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_NOT = 3'b101;
  localparam op_t OP_SHL = 3'b110;
  localparam op_t OP_SHR = 3'b111;

  typedef struct packed {
    logic zf;
    logic cf;
    logic of;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op/a/b -> y and {zf,cf,of}.
// Define ALU_SAT_EN to clamp signed-overflowing ADD/SUB results instead of wrapping.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output flags_t           flags
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic             big_shift;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] y_i;
  logic             cf_i;
  logic             of_i;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // One extra bit beside the operand catches the last bit shifted out.
  assign shl_ext   = {1'b0, a} << b;
  assign shr_ext   = {a, 1'b0} >> b;
  assign big_shift = (b >= W_VAL);

  assign add_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    y_i  = '0;
    cf_i = 1'b0;
    of_i = 1'b0;
    case (op)
      OP_ADD: begin y_i = sum[WIDTH-1:0];  cf_i = sum[WIDTH];  of_i = add_of; end
      OP_SUB: begin y_i = diff[WIDTH-1:0]; cf_i = diff[WIDTH]; of_i = sub_of; end
      OP_AND: y_i = a & b;
      OP_OR:  y_i = a | b;
      OP_XOR: y_i = a ^ b;
      OP_NOT: y_i = ~a;
      OP_SHL: if (!big_shift) begin
        y_i  = shl_ext[WIDTH-1:0];
        cf_i = shl_ext[WIDTH];
      end
      OP_SHR: if (!big_shift) begin
        y_i  = shr_ext[WIDTH:1];
        cf_i = shr_ext[0];
      end
    endcase
`ifdef ALU_SAT_EN
    if ((op == OP_ADD || op == OP_SUB) && of_i)
      y_i = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  assign y     = y_i;
  assign flags = '{zf: (y_i == '0), cf: cf_i, of: of_i};

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: stage 1 holds operands, stage 2 holds results.
// Optional ALU_SAT_EN (see alu_core) selects saturating ADD/SUB.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zf,
  output logic             out_cf,
  output logic             out_of
);

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  flags_t           s2_flags;

  logic [WIDTH-1:0] core_y;
  flags_t           core_flags;
  logic             s2_adv;

  // No skid buffer: a full pipe accepts only when the consumer drains this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // NOTE: datapath registers are reset too so outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (s1_op),
    .a     (s1_a),
    .b     (s1_b),
    .y     (core_y),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= core_y;
        s2_flags <= core_flags;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_zf    = s2_flags.zf;
  assign out_cf    = s2_flags.cf;
  assign out_of    = s2_flags.of;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=6): directed vectors, throughput,
// backpressure, reset flush and randomized traffic against an arithmetic model.
module tb_alu_pipe;

  localparam int W    = 6;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_y;
  logic         out_zf, out_cf, out_of;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zf    (out_zf),
    .out_cf    (out_cf),
    .out_of    (out_of)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zf;
    logic         cf;
    logic         of;
  } res_t;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic on unsigned and signed readings.
  function automatic res_t model(input int op, input int a, input int b);
    res_t r;
    int   y, sa, sb, s;
    r  = '0;
    y  = 0;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    case (op)
      0: begin
        y    = (a + b) % MOD;
        r.cf = (a + b) >= MOD;
        s    = sa + sb;
        r.of = (s > HALF - 1) || (s < -HALF);
      end
      1: begin
        y    = (a - b + MOD) % MOD;
        r.cf = a < b;
        s    = sa - sb;
        r.of = (s > HALF - 1) || (s < -HALF);
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = MOD - 1 - a;
      6: if (b == 0) y = a;
         else if (b < W) begin
           y    = (a * (1 << b)) % MOD;
           r.cf = ((a >> (W - b)) & 1) != 0;
         end
      default: if (b == 0) y = a;
         else if (b < W) begin
           y    = a / (1 << b);
           r.cf = ((a >> (b - 1)) & 1) != 0;
         end
    endcase
`ifdef ALU_SAT_EN
    if (op <= 1 && r.of) y = (sa >= 0) ? HALF - 1 : HALF;
`endif
    r.y  = W'(y);
    r.zf = (y == 0);
    return r;
  endfunction

  function automatic res_t got_res();
    return '{y: out_y, zf: out_zf, cf: out_cf, of: out_of};
  endfunction

  task automatic check_res(input string name, input res_t got, input res_t exp);
    check({name, ".y"},  32'(got.y),  32'(exp.y));
    check({name, ".zf"}, 32'(got.zf), 32'(exp.zf));
    check({name, ".cf"}, 32'(got.cf), 32'(exp.cf));
    check({name, ".of"}, 32'(got.of), 32'(exp.of));
  endtask

  // Issue one op on an idle pipe, wait for its result, and report the cycle latency.
  task automatic run_one(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output res_t got, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int n = 1; n <= 6; n++) begin
      if (out_valid) begin
        lat = n;
        got = got_res();
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t  vecs[14];
  res_t  q[$];
  res_t  got, ref_r, held;
  int    lat, acc, c;

  initial begin
`ifdef ALU_SAT_EN
    vecs[0] = '{"add_31_1",   3'd0, 6'd31,  6'd1,  '{6'd31,   1'b0, 1'b0, 1'b1}};
    vecs[12] = '{"sub_m32_1", 3'd1, 6'h20,  6'd1,  '{6'h20,   1'b0, 1'b0, 1'b1}};
`else
    vecs[0] = '{"add_31_1",   3'd0, 6'd31,  6'd1,  '{6'd32,   1'b0, 1'b0, 1'b1}};
    vecs[12] = '{"sub_m32_1", 3'd1, 6'h20,  6'd1,  '{6'h1F,   1'b0, 1'b0, 1'b1}};
`endif
    vecs[1]  = '{"sub_5_6",   3'd1, 6'd5,   6'd6,  '{6'h3F,   1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{"sub_9_9",   3'd1, 6'd9,   6'd9,  '{6'h00,   1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{"shl_21_1",  3'd6, 6'h21,  6'd1,  '{6'h02,   1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{"shr_21_6",  3'd7, 6'h21,  6'd6,  '{6'h00,   1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{"shr_21_0",  3'd7, 6'h21,  6'd0,  '{6'h21,   1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{"and",       3'd2, 6'h2A,  6'h0F, '{6'h0A,   1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{"or",        3'd3, 6'h20,  6'h01, '{6'h21,   1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{"xor_zero",  3'd4, 6'h3F,  6'h3F, '{6'h00,   1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{"not",       3'd5, 6'h15,  6'h00, '{6'h2A,   1'b0, 1'b0, 1'b0}};
    vecs[10] = '{"add_63_1",  3'd0, 6'h3F,  6'd1,  '{6'h00,   1'b1, 1'b1, 1'b0}};
    vecs[11] = '{"shr_21_1",  3'd7, 6'h21,  6'd1,  '{6'h10,   1'b0, 1'b1, 1'b0}};
    vecs[13] = '{"shl_21_5",  3'd6, 6'h21,  6'd5,  '{6'h20,   1'b0, 1'b0, 1'b0}};

    // Reset state
    #12;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_y", 32'(out_y), 0);
    check("rst.flags", 32'({out_zf, out_cf, out_of}), 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst.in_ready", 32'(in_ready), 1);

    // Directed vectors on an idle pipe
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_one(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check({vecs[i].name, ".latency"}, 32'(lat), 2);
      check_res(vecs[i].name, got, vecs[i].exp);
    end

    // Back-to-back 8 ops: results on consecutive cycles starting at cycle 2
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      check($sformatf("b2b.valid@%0d", cyc), 32'(out_valid), 32'(cyc >= 2 && cyc < 10));
      if (out_valid) begin
        if (q.size() == 0) check("b2b.unexpected", 1, 0);
        else check_res($sformatf("b2b.res@%0d", cyc), got_res(), q.pop_front());
      end
      in_valid = (cyc < 8);
      if (cyc < 8) begin
        in_op = 3'($urandom_range(0, 7)); in_a = W'($urandom); in_b = W'($urandom_range(0, 7));
        q.push_back(model(in_op, in_a, in_b));
      end
    end
    in_valid = 1'b0;
    q.delete();

    // Backpressure: exactly two ops accepted, outputs held stable
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; in_op = 3'd0; in_a = W'(cyc + 3); in_b = W'(cyc);
      #1;
      if (in_valid && in_ready) begin
        acc++;
        q.push_back(model(in_op, in_a, in_b));
      end
      if (cyc == 2) held = got_res();
      if (cyc > 2) check_res($sformatf("hold.stable@%0d", cyc), got_res(), held);
      @(negedge clk);
    end
    check("hold.accepted", 32'(acc), 2);
    #1 check("hold.in_ready", 32'(in_ready), 0);
    check("hold.out_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() > 0 && c < 6) begin
      #1;
      if (out_valid) check_res("hold.drain", got_res(), q.pop_front());
      @(negedge clk);
      c++;
    end
    check("hold.drained", 32'(q.size()), 0);
    q.delete();

    // Reset with two ops in flight
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd3; in_a = 6'h11; in_b = 6'h22;
    @(negedge clk);
    in_op = 3'd0; in_a = 6'h05; in_b = 6'h07;
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight.out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("flush.out_valid", 32'(out_valid), 0);
    check("flush.out_y", 32'(out_y), 0);
    check("flush.flags", 32'({out_zf, out_cf, out_of}), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check($sformatf("flush.no_stale@%0d", cyc), 32'(out_valid), 0);
    end

    // Randomized traffic with random backpressure against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op = 3'($urandom_range(0, 7));
      in_a  = W'($urandom);
      in_b  = (in_op >= 3'd6) ? W'($urandom_range(0, 9)) : W'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand.unexpected", 1, 0);
        else begin
          ref_r = q.pop_front();
          check_res("rand.res", got_res(), ref_r);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() > 0 && c < 8) begin
      #1;
      if (out_valid) check_res("rand.drain", got_res(), q.pop_front());
      @(negedge clk);
      c++;
    end
    check("rand.drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
